// File: rtl/tug_pkg.sv
// Shared types for the tug-of-war playing field: field states and the winner encoding.
package tug_pkg;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    LWON = 2'd1,
    RWON = 2'd2
  } field_state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_L    = 2'b10;
  localparam logic [1:0] WIN_R    = 2'b01;

  function automatic logic [1:0] win_code(input field_state_e st);
    case (st)
      LWON:    win_code = WIN_L;
      RWON:    win_code = WIN_R;
      default: win_code = WIN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/tug_key_press.sv
// Key-to-pulse converter: optional two-flop synchronizer (FIELD_SYNC_EN) ahead of a rising-edge detector.
module tug_key_press (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic press
);

  logic sample;
  logic prev;

`ifdef FIELD_SYNC_EN
  logic sync1;
  logic sync2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

  assign sample = sync2;
`else
  assign sample = key;
`endif

  // History resets high so a key held through reset release never counts as a press.
  always_ff @(posedge clk) begin
    if (!reset) prev <= 1'b1;
    else        prev <= sample;
  end

  assign press = sample & ~prev;

endmodule

// File: rtl/tug_field.sv
// Tug-of-war playing field: moves one lit LED on key presses and freezes once a side pulls past its end.
// Optional macro FIELD_SYNC_EN adds a two-flop key synchronizer in tug_key_press.
module tug_field
  import tug_pkg::*;
#(
  parameter int N_LEDS = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              L,
  input  logic              R,
  input  logic              restart,
  output logic [N_LEDS-1:0] led,
  output logic              L_endLED,
  output logic              R_endLED,
  output logic              L_press,
  output logic              R_press,
  output logic [1:0]        winner
);

  localparam int POS_W = $clog2(N_LEDS);
  localparam logic [POS_W-1:0] CENTER = POS_W'((N_LEDS - 1) / 2);
  localparam logic [POS_W-1:0] LAST   = POS_W'(N_LEDS - 1);

  field_state_e     state, state_next;
  logic [POS_W-1:0] pos, pos_next;
  logic             l_raw, r_raw;
  logic             l_only, r_only;

  tug_key_press u_left (
    .clk   (clk),
    .reset (reset),
    .key   (L),
    .press (l_raw)
  );

  tug_key_press u_right (
    .clk   (clk),
    .reset (reset),
    .key   (R),
    .press (r_raw)
  );

  // Simultaneous presses cancel; pulses are only exported while play is live.
  assign l_only  = l_raw & ~r_raw;
  assign r_only  = r_raw & ~l_raw;
  assign L_press = l_only & (state == PLAY);
  assign R_press = r_only & (state == PLAY);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= PLAY;
      pos   <= CENTER;
    end else begin
      state <= state_next;
      pos   <= pos_next;
    end
  end

  always_comb begin
    state_next = state;
    pos_next   = pos;
    if (restart) begin
      state_next = PLAY;
      pos_next   = CENTER;
    end else if (state == PLAY) begin
      if (l_only) begin
        if (pos == LAST) state_next = LWON;
        else             pos_next   = pos + POS_W'(1);
      end else if (r_only) begin
        if (pos == '0)   state_next = RWON;
        else             pos_next   = pos - POS_W'(1);
      end
    end
  end

  assign led      = {{(N_LEDS - 1){1'b0}}, 1'b1} << pos;
  assign L_endLED = led[N_LEDS-1];
  assign R_endLED = led[0];
  assign winner   = win_code(state);

endmodule

// File: tb/tb_tug_field.sv
// Self-checking bench for tug_field: per-cycle model comparison plus directed literal checks.
`timescale 1ns/1ps
module tb_tug_field;

  localparam int N = 9;
  localparam int C = (N - 1) / 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         L, R, restart;
  logic [N-1:0] led;
  logic         L_endLED, R_endLED, L_press, R_press;
  logic [1:0]   winner;

  int n_cmp = 0;
  int n_bad = 0;

  tug_field #(.N_LEDS(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .L        (L),
    .R        (R),
    .restart  (restart),
    .led      (led),
    .L_endLED (L_endLED),
    .R_endLED (R_endLED),
    .L_press  (L_press),
    .R_press  (R_press),
    .winner   (winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: position as an integer, game result as 0=none/1=left/2=right.
  int m_pos = C;
  int m_win = 0;
  int m_prev_l = 1, m_prev_r = 1;
  int m_s1l = 0, m_s2l = 0, m_s1r = 0, m_s2r = 0;
  bit m_valid = 0;

  always @(negedge clk) begin
    int sl, sr, pl, pr, el, er;
    logic [N-1:0] exp_led;
`ifdef FIELD_SYNC_EN
    sl = m_s2l; sr = m_s2r;
`else
    sl = int'(L); sr = int'(R);
`endif
    pl = (sl == 1 && m_prev_l == 0) ? 1 : 0;
    pr = (sr == 1 && m_prev_r == 0) ? 1 : 0;
    el = (m_win == 0 && pl == 1 && pr == 0) ? 1 : 0;
    er = (m_win == 0 && pr == 1 && pl == 0) ? 1 : 0;
    if (m_valid && reset === 1'b1) begin
      exp_led = '0;
      exp_led[m_pos] = 1'b1;
      chk("led", 32'(led), 32'(exp_led));
      chk("L_endLED", 32'(L_endLED), (m_pos == N - 1) ? 32'd1 : 32'd0);
      chk("R_endLED", 32'(R_endLED), (m_pos == 0) ? 32'd1 : 32'd0);
      chk("L_press", 32'(L_press), 32'(el));
      chk("R_press", 32'(R_press), 32'(er));
      chk("winner", 32'(winner), (m_win == 1) ? 32'd2 : (m_win == 2) ? 32'd1 : 32'd0);
    end
    // Advance the model to the state after the coming posedge (inputs are stable until then).
    if (reset === 1'b0) begin
      m_pos = C; m_win = 0; m_prev_l = 1; m_prev_r = 1;
      m_s1l = 0; m_s2l = 0; m_s1r = 0; m_s2r = 0;
      m_valid = 1;
    end else begin
      m_prev_l = sl; m_prev_r = sr;
      m_s2l = m_s1l; m_s1l = int'(L);
      m_s2r = m_s1r; m_s1r = int'(R);
      if (restart) begin
        m_pos = C; m_win = 0;
      end else if (el == 1) begin
        if (m_pos == N - 1) m_win = 1; else m_pos++;
      end else if (er == 1) begin
        if (m_pos == 0) m_win = 2; else m_pos--;
      end
    end
  end

  // One clock cycle: apply inputs just after posedge, return just after the following negedge.
  task automatic cyc(input logic rst_n, input logic l, input logic r, input logic rs);
    @(posedge clk);
    #1;
    reset = rst_n; L = l; R = r; restart = rs;
    @(negedge clk);
    #1;
  endtask

  task automatic press_l();
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
  endtask

  task automatic press_r();
    cyc(1, 0, 1, 0);
    cyc(1, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b0; L = 1'b0; R = 1'b0; restart = 1'b0;
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("lit_reset_led", 32'(led), 32'h010);
    chk("lit_reset_win", 32'(winner), 32'd0);
    chk("lit_reset_ends", 32'({L_endLED, R_endLED}), 32'd0);
    chk("lit_reset_press", 32'({L_press, R_press}), 32'd0);

`ifdef FIELD_SYNC_EN
    cyc(1, 1, 0, 0);
    chk("lit_sync_p0", 32'(L_press), 32'd0);
    cyc(1, 1, 0, 0);
    chk("lit_sync_p1", 32'(L_press), 32'd0);
    cyc(1, 1, 0, 0);
    chk("lit_sync_p2", 32'(L_press), 32'd1);
    chk("lit_sync_led_pre", 32'(led), 32'h010);
    cyc(1, 1, 0, 0);
    chk("lit_sync_led_post", 32'(led), 32'h020);
    chk("lit_sync_p3", 32'(L_press), 32'd0);
    for (int unsigned i = 0; i < 6; i++) cyc(1, 0, 0, 0);
    for (int unsigned i = 0; i < 4; i++) begin
      press_l(); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    end
    chk("lit_sync_lwin", 32'(winner), 32'd2);
`else
    // Held key: exactly one press and one move.
    cyc(1, 1, 0, 0);
    chk("lit_held_press", 32'(L_press), 32'd1);
    chk("lit_held_led_pre", 32'(led), 32'h010);
    cyc(1, 1, 0, 0);
    chk("lit_held_press2", 32'(L_press), 32'd0);
    chk("lit_held_led", 32'(led), 32'h020);
    for (int unsigned i = 0; i < 3; i++) cyc(1, 1, 0, 0);
    chk("lit_held_led_stay", 32'(led), 32'h020);
    cyc(1, 0, 0, 0);

    // Left win.
    for (int unsigned i = 0; i < 3; i++) press_l();
    chk("lit_lend_led", 32'(led), 32'h100);
    chk("lit_lend_flag", 32'(L_endLED), 32'd1);
    cyc(1, 1, 0, 0);
    chk("lit_lwin_press", 32'({L_press, L_endLED}), 32'h3);
    cyc(1, 0, 0, 0);
    chk("lit_lwin_winner", 32'(winner), 32'd2);
    cyc(1, 1, 0, 0);
    chk("lit_lwon_lpress", 32'(L_press), 32'd0);
    cyc(1, 0, 1, 0);
    chk("lit_lwon_rpress", 32'(R_press), 32'd0);
    cyc(1, 0, 0, 0);
    chk("lit_lwon_frozen", 32'(led), 32'h100);

    // Restart back to centre, then simultaneous presses cancel.
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 0);
    chk("lit_restart1_led", 32'(led), 32'h010);
    chk("lit_restart1_win", 32'(winner), 32'd0);
    cyc(1, 1, 1, 0);
    chk("lit_both_press", 32'({L_press, R_press}), 32'd0);
    cyc(1, 0, 0, 0);
    chk("lit_both_led", 32'(led), 32'h010);

    // Right win.
    for (int unsigned i = 0; i < 4; i++) press_r();
    chk("lit_rend_led", 32'(led), 32'h001);
    chk("lit_rend_flag", 32'(R_endLED), 32'd1);
    press_r();
    chk("lit_rwin_winner", 32'(winner), 32'd1);

    // Restart beats a simultaneous R rise.
    cyc(1, 0, 1, 1);
    chk("lit_restart2_rpress", 32'(R_press), 32'd0);
    cyc(1, 0, 1, 0);
    chk("lit_restart2_led", 32'(led), 32'h010);
    chk("lit_restart2_win", 32'(winner), 32'd0);
    cyc(1, 0, 0, 0);
    chk("lit_restart2_nomove", 32'(led), 32'h010);

    // Reset with L held: no move on release, then one move on a fresh press.
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    chk("lit_rsthold_led", 32'(led), 32'h010);
    chk("lit_rsthold_press", 32'(L_press), 32'd0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    chk("lit_rsthold_repress", 32'(L_press), 32'd1);
    cyc(1, 0, 0, 0);
    chk("lit_rsthold_move", 32'(led), 32'h020);
`endif

    // Random key activity exercised against the model only.
    for (int unsigned i = 0; i < 300; i++)
      cyc(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
    cyc(1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tug_field.md
Name: tug_field

Overview:
- Playing-field driver for the tug-of-war game; produces the signals the winner/HEX display logic consumes.
- Turns raw player keys into one-cycle press pulses.
- Moves a single lit LED across an N-LED field and drives the two end-LED flags.
- Freezes the field once a player pulls past an end.

Parameters:
- N_LEDS, 9, field width; must be odd and at least 3. CENTER = (N_LEDS-1)/2. led[N_LEDS-1] is the leftmost LED; led[0] is the rightmost.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset; asserted when 0, sampled on posedge clk
- L  in  1  left-player (player 2) key, active-high, asynchronous to clk
- R  in  1  right-player (player 1) key, active-high, asynchronous to clk
- restart  in  1  synchronous round restart, active-high, one cycle
- led  out  N_LEDS  field LEDs
- L_endLED  out  1  equals led[N_LEDS-1]
- R_endLED  out  1  equals led[0]
- L_press  out  1  one-cycle left-press pulse
- R_press  out  1  one-cycle right-press pulse
- winner  out  2  00 = none, 10 = left won, 01 = right won

Behaviour:
- Reset (reset==0 at posedge):
  - State goes to PLAY and pos goes to CENTER, so led is one-hot at CENTER.
  - winner=00; L_endLED=R_endLED=0 (for N_LEDS>=3).
  - Edge-detect history flops are set to 1, so a key held through reset release is not a press.
- Press detection, per key: press = sample & ~prev; prev <= sample every cycle. A held key gives exactly one press.
- L_press and R_press:
  - Combinational from the press terms in the same cycle, against the pre-move position.
  - This lets downstream logic test L_press & L_endLED consistently.
  - Both are forced to 0 when both presses occur in the same cycle, or when state is not PLAY.
- pos register: width $clog2(N_LEDS); led = 1 << pos in every state.
- FSM states: PLAY, LWON, RWON.
- PLAY:
  - Left press only, pos<N_LEDS-1: pos+1 at next edge.
  - Left press only, pos==N_LEDS-1: go to LWON; pos held.
  - Right press only, pos>0: pos-1.
  - Right press only, pos==0: go to RWON.
  - Both presses, or neither: no change.
- LWON / RWON:
  - Terminal; all key activity ignored; led frozen on the end LED.
  - winner=10 in LWON, 01 in RWON; 00 otherwise.
- restart:
  - From any state: next edge gives PLAY and pos=CENTER.
  - Has priority over a press in the same cycle; edge history is not cleared.
- Latency: move or win is visible one cycle after the first high sample of the key.
- No wrap-around: pos never leaves 0..N_LEDS-1.
- Priority: reset > restart > press logic.

Optional Feature:
- Macro FIELD_SYNC_EN.
- Defined: each key passes through a two-flop synchronizer before the edge detector.
  - The press pulse appears 2 cycles after the key is first sampled; the move follows 1 cycle later.
  - Synchronizer flops reset to 0; the edge history still resets to 1.
- Undefined: keys feed the edge detector directly, with the latencies given above.

Decomposition:
- Package tug_pkg:
  - field_state_e enum {PLAY, LWON, RWON}.
  - winner encoding constants WIN_NONE=2'b00, WIN_L=2'b10, WIN_R=2'b01.
- Sub-module tug_key_press: optional synchronizer plus edge detector, with ports clk, reset, key, press. Instantiated once per player.

Test Plan (N_LEDS=9, FIELD_SYNC_EN undefined unless stated):
- Reset: hold reset=0 one cycle, then release -> led=9'b000010000, winner=00, L_endLED=R_endLED=0, no press pulses.
- Held key: L held high 5 cycles -> L_press high exactly one cycle; led=9'b000100000 the following cycle; no further moves.
- Left win: four separate L presses -> led=9'b100000000 and L_endLED=1. Fifth press -> L_press=1 with L_endLED=1 that cycle, winner=10 next cycle. Further L and R presses -> no change, press pulses stay 0.
- Simultaneous presses: L and R rise in the same cycle at CENTER -> L_press=R_press=0 and led unchanged. Then four R presses followed by a fifth -> winner=01.
- Restart: restart=1 while in RWON, with R rising the same cycle -> next cycle PLAY, led=9'b000010000, winner=00.
- Reset with key held: reset asserted while L held, released with L still high -> no move. L low then high again -> one move left.
- With FIELD_SYNC_EN: L press from CENTER -> L_press appears 2 cycles later than in the undefined build; led moves one cycle after that.
